// File: rtl/seq_scan_ctrl.sv
// Serial 4-bit pattern scanner: words are accepted one at a time and shifted out MSB first,
// counting pattern matches per packet; one word per WORD_W+1 cycles, in_ready only while IDLE.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              clear,
  output logic              det_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done,
  output logic              busy
);

  localparam int BC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q;
  logic [WORD_W-1:0] sr_q;
  logic              last_q;
  logic [BC_W-1:0]   bitcnt_q;
  logic [3:0]        hist_q;
  logic [2:0]        fill_q;
  logic [3:0]        pat_q;
  logic              ovl_q;
  logic              in_pkt_q;
  logic              det_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        hist_d;
  logic [2:0]        fill_d;
  logic              match_d;
  logic [CNT_W-1:0]  cnt_d;

  // Post-shift view of the history, used both for the match test and the update.
  always_comb begin
    hist_d  = {hist_q[2:0], sr_q[WORD_W-1]};
    fill_d  = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    match_d = (hist_d == pat_q) && (fill_d == 3'd4);
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      last_q   <= 1'b0;
      bitcnt_q <= '0;
      hist_q   <= 4'd0;
      fill_q   <= 3'd0;
      pat_q    <= 4'd0;
      ovl_q    <= 1'b0;
      in_pkt_q <= 1'b0;
      det_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (clear) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      last_q   <= 1'b0;
      bitcnt_q <= '0;
      hist_q   <= 4'd0;
      fill_q   <= 3'd0;
      in_pkt_q <= 1'b0;
      det_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      det_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q     <= in_data;
            last_q   <= in_last;
            bitcnt_q <= BC_W'(WORD_W);
            state_q  <= SHIFT;
            // Configuration is frozen for the whole packet at its first word.
            if (!in_pkt_q) begin
              pat_q    <= cfg_pattern;
              ovl_q    <= cfg_overlap;
              cnt_q    <= '0;
              in_pkt_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sr_q     <= sr_q << 1;
          hist_q   <= hist_d;
          bitcnt_q <= bitcnt_q - BC_W'(1);
          if (match_d) begin
            det_q  <= 1'b1;
            cnt_q  <= cnt_d;
            fill_q <= ovl_q ? fill_d : 3'd0;
          end else begin
            fill_q <= fill_d;
          end
          if (bitcnt_q == BC_W'(1)) begin
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          state_q  <= IDLE;
          in_pkt_q <= 1'b0;
          hist_q   <= 4'd0;
          fill_q   <= 3'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign det_pulse = det_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;
  assign busy      = in_pkt_q || (state_q != IDLE);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a default instance plus a CNT_W=2 instance sharing all inputs.
module tb_seq_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       clear;

  logic       rdy0, det0, done0, busy0;
  logic [7:0] cnt0;
  logic       rdy1, det1, done1, busy1;
  logic [1:0] cnt1;

  int vecs = 0;
  int errs = 0;

  seq_scan_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clear(clear),
    .det_pulse(det0), .match_cnt(cnt0), .done(done0), .busy(busy0)
  );

  seq_scan_ctrl #(.WORD_W(8), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clear(clear),
    .det_pulse(det1), .match_cnt(cnt1), .done(done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_word(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick;
    in_valid = 1'b0;
  endtask

  // Eight SHIFT edges; bit k of the masks is det_pulse after bit k+1 of the word.
  task automatic run_bits(output logic [7:0] m0, output logic [7:0] m1);
    m0 = 8'h00;
    m1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick;
      m0[k] = det0;
      m1[k] = det1;
      if (k == 2) in_valid = 1'b0;
    end
  endtask

  logic [7:0] m0, m1;
  logic       seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    cfg_pattern = 4'b0000; cfg_overlap = 1'b0; clear = 1'b0;
    repeat (3) tick;
    chk("rst_ready", 32'(rdy0), 1);
    chk("rst_det",   32'(det0), 0);
    chk("rst_done",  32'(done0), 0);
    chk("rst_busy",  32'(busy0), 0);
    chk("rst_cnt",   32'(cnt0), 0);
    rst_n = 1'b1;
    tick;

    // Overlapping 1010 in 10101010; stray in_valid during SHIFT must be ignored.
    cfg_pattern = 4'b1010; cfg_overlap = 1'b1;
    accept_word(8'hAA, 1'b1);
    chk("shift_ready", 32'(rdy0), 0);
    chk("shift_busy",  32'(busy0), 1);
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b0;
    run_bits(m0, m1);
    chk("ovl_mask", 32'(m0), 'hA8);
    chk("ovl_done", 32'(done0), 1);
    chk("ovl_cnt",  32'(cnt0), 3);
    tick;
    chk("post_done",  32'(done0), 0);
    chk("post_det",   32'(det0), 0);
    chk("post_ready", 32'(rdy0), 1);
    chk("post_busy",  32'(busy0), 0);
    chk("post_cnt_hold", 32'(cnt0), 3);

    // Non-overlapping; mid-packet cfg changes must not take effect.
    cfg_overlap = 1'b0;
    accept_word(8'hAA, 1'b1);
    cfg_pattern = 4'b0000; cfg_overlap = 1'b1;
    run_bits(m0, m1);
    chk("novl_mask", 32'(m0), 'h88);
    chk("novl_done", 32'(done0), 1);
    chk("novl_cnt",  32'(cnt0), 2);
    tick;

    // Match spanning a word boundary.
    cfg_pattern = 4'b1010; cfg_overlap = 1'b1;
    accept_word(8'h05, 1'b0);
    chk("span_cnt_zeroed", 32'(cnt0), 0);
    run_bits(m0, m1);
    chk("span_mask1", 32'(m0), 'h00);
    chk("span_gap_ready", 32'(rdy0), 1);
    chk("span_gap_busy",  32'(busy0), 1);
    chk("span_gap_done",  32'(done0), 0);
    accept_word(8'h00, 1'b1);
    chk("span_ready2", 32'(rdy0), 0);
    run_bits(m0, m1);
    chk("span_mask2", 32'(m0), 'h01);
    chk("span_done",  32'(done0), 1);
    chk("span_cnt",   32'(cnt0), 1);
    tick;

    // Saturation on the narrow-counter instance.
    cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    accept_word(8'hFF, 1'b1);
    run_bits(m0, m1);
    chk("sat_mask0", 32'(m0), 'hF8);
    chk("sat_cnt0",  32'(cnt0), 5);
    chk("sat_mask1", 32'(m1), 'hF8);
    chk("sat_cnt1",  32'(cnt1), 3);
    chk("sat_done1", 32'(done1), 1);
    tick;

    // Clear during bit 3 of the second word, right after a match.
    cfg_pattern = 4'b1010; cfg_overlap = 1'b1;
    accept_word(8'hAA, 1'b0);
    run_bits(m0, m1);
    chk("clr_w1_cnt", 32'(cnt0), 3);
    accept_word(8'hAA, 1'b1);
    tick;
    chk("clr_bit1_det", 32'(det0), 0);
    tick;
    chk("clr_bit2_det", 32'(det0), 1);
    chk("clr_bit2_cnt", 32'(cnt0), 4);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_ready", 32'(rdy0), 1);
    chk("clr_cnt",   32'(cnt0), 0);
    chk("clr_busy",  32'(busy0), 0);
    chk("clr_det",   32'(det0), 0);
    chk("clr_done",  32'(done0), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen = seen | det0 | done0;
    end
    chk("clr_quiet", 32'(seen), 0);
    cfg_overlap = 1'b0;
    accept_word(8'hAA, 1'b1);
    run_bits(m0, m1);
    chk("clr_next_mask", 32'(m0), 'h88);
    chk("clr_next_cnt",  32'(cnt0), 2);
    chk("clr_next_done", 32'(done0), 1);
    tick;

    // Asynchronous reset at bit 5.
    cfg_pattern = 4'b1010; cfg_overlap = 1'b1;
    accept_word(8'hAA, 1'b1);
    repeat (4) tick;
    chk("rst_mid_det4", 32'(det0), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(rdy0), 1);
    chk("arst_det",   32'(det0), 0);
    chk("arst_done",  32'(done0), 0);
    chk("arst_busy",  32'(busy0), 0);
    chk("arst_cnt",   32'(cnt0), 0);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen = seen | det0 | done0;
    end
    chk("arst_quiet", 32'(seen), 0);
    cfg_pattern = 4'b0101; cfg_overlap = 1'b0;
    accept_word(8'h05, 1'b1);
    run_bits(m0, m1);
    chk("arst_next_mask", 32'(m0), 'h80);
    chk("arst_next_cnt",  32'(cnt0), 1);
    chk("arst_next_done", 32'(done0), 1);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
